timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
Parametrised successor to the dual timer: NUM_CH independent down-counting timer channels behind one memory-mapped register window on the I/O bus.
- Per-channel controls: prescaler, one-shot or periodic mode, and interrupt enable.
- Sticky, write-1-to-clear pending flags.
- Outputs: a per-channel IRQ vector, a combined IRQ line, and a priority-encoded channel ID.
- The combined IRQ line and ID feed the interrupt module in place of the fixed clock/millis IRQs.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
WIDTH, 32, counter/LOAD width in bits (8..32); register reads are zero-extended to 32
PRESC_W, 8, per-channel prescaler width (1..16)
ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= 4*NUM_CH+2

Ports:
clk  in  1  processor clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
addr  in  ADDR_W  register word address (from io_addr low bits)
data_in  in  32  write data
write_enable  in  1  register write strobe, one write per cycle
data_out  out  32  read data, combinational from addr and current state
irq_vec  out  NUM_CH  per-channel pending & irq_en
irq  out  1  OR of irq_vec
irq_id  out  max(1,clog2(NUM_CH))  lowest index set in irq_vec; 0 when irq=0

Behaviour:
Register map (word addresses):
- ch*4+0 LOAD: R/W, WIDTH bits.
- ch*4+1 COUNT: R/W; a write forces the counter.
- ch*4+2 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN, bits[8+PRESC_W-1:8] PRESC.
- ch*4+3: reserved; reads 0, writes ignored.
- 4*NUM_CH STATUS: bit ch = pending[ch]; a write clears every bit written as 1.
- 4*NUM_CH+1 INFO: reads {WIDTH[7:0], PRESC_W[7:0], 8'd0, NUM_CH[7:0]}; read-only.
- Any other address reads 0; writes to it are ignored.
- Writes to unused upper bits are dropped. Reads return unused bits as 0.

Reset: every LOAD, COUNT, CTRL, prescaler counter and pending bit is 0. All outputs are 0.

Per channel, each cycle with EN=1:
- If presc_cnt == PRESC: tick; presc_cnt <= 0.
- Otherwise: presc_cnt <= presc_cnt+1.

On a tick:
- COUNT != 0: COUNT <= COUNT-1.
- COUNT == 0: expiry. pending <= 1 (set regardless of IRQ_EN).
  - PERIODIC=1: COUNT <= LOAD.
  - PERIODIC=0: EN <= 0; COUNT stays 0.
- Period = (LOAD+1)*(PRESC+1) cycles. LOAD=0 with PERIODIC=1 expires every PRESC+1 cycles.

EN=0: counter and prescaler hold.

CTRL write with EN going 0->1: COUNT <= LOAD and presc_cnt <= 0 on that edge. The first tick follows PRESC+1 cycles later.

A CTRL write with EN=1 while already enabled updates mode, IRQ_EN and PRESC only. The count continues. presc_cnt is not reset; if presc_cnt > new PRESC, it wraps to 0 at its own overflow.

Simultaneous-event priority, highest first:
1. rst
2. register write to the same field
3. count/tick update

Specific cases:
- COUNT write in the same cycle as a tick: the written value wins. No expiry is generated that cycle.
- STATUS clear in the same cycle as an expiry on that channel: the set wins (pending stays 1).
- Reads have no side effects.

irq_vec, irq and irq_id are combinational from the registered pending/IRQ_EN bits. The IRQ asserts the cycle after the expiry edge.

A reset mid-count returns every channel to its reset state on that edge. No expiry is generated.

Decomposition:
timer_bank_pkg holds:
- register offsets: OFF_LOAD=0, OFF_COUNT=1, OFF_CTRL=2, the STATUS/INFO offset rule;
- CTRL bit positions (EN_BIT, PER_BIT, IEN_BIT, PRESC_LSB);
- the clog2 helper.

One sub-module, timer_channel: holds LOAD/COUNT/CTRL/prescaler/pending for one channel. It takes decoded per-field write strobes and a pending-clear input, and outputs its register values and pending. It is instantiated NUM_CH times in a generate loop. The top level does address decode, read mux and the priority encoder.

Test Plan:
- Reset, then read INFO and all registers -> INFO=0x20080004, every other register 0, irq=0.
- ch0: LOAD=3, CTRL=0x7 (EN, PERIODIC, IRQ_EN, PRESC=0) -> irq rises 4 cycles after the CTRL write edge, then every 4 cycles; STATUS=0x1; writing STATUS=0x1 clears it until the next expiry.
- ch1: LOAD=2, CTRL=0x0205 (one-shot, IRQ_EN, PRESC=2) -> exactly one expiry after 9 cycles; CTRL.EN reads 0 afterwards; COUNT reads 0; no further expiries.
- ch2 and ch3 both expire in the same cycle with IRQ_EN set -> irq_vec=0b1100, irq_id=2; clear bit 2 -> irq_id=3; clear bit 3 -> irq=0.
- STATUS W1C write for ch0 in the same cycle as a ch0 expiry -> pending[0] remains 1. COUNT write of 10 in the same cycle as a ch0 tick -> COUNT reads 10.
- ch0 with IRQ_EN=0, LOAD=1 -> STATUS bit0 sets but irq stays 0. Setting IRQ_EN -> irq asserts next cycle. rst mid-count -> all registers read 0 next cycle.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared register-map constants and helpers for the timer_bank channel array.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        OFF_LOAD  = 2'd0,
        OFF_COUNT = 2'd1,
        OFF_CTRL  = 2'd2,
        OFF_RSVD  = 2'd3
    } reg_off_e;

    localparam int EN_BIT    = 0;
    localparam int PER_BIT   = 1;
    localparam int IEN_BIT   = 2;
    localparam int PRESC_LSB = 8;

    // STATUS and INFO sit directly after the last channel's four-word block.
    function automatic int status_addr(input int num_ch);
        return 4 * num_ch;
    endfunction

    function automatic int info_addr(input int num_ch);
        return 4 * num_ch + 1;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer: LOAD/COUNT/CTRL registers, prescaler and sticky pending flag.
module timer_channel import timer_bank_pkg::*; #(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        wdata_i,
    input  logic               load_we_i,
    input  logic               count_we_i,
    input  logic               ctrl_we_i,
    input  logic               clr_i,
    output logic [WIDTH-1:0]   load_o,
    output logic [WIDTH-1:0]   count_o,
    output logic               en_o,
    output logic               periodic_o,
    output logic               ien_o,
    output logic [PRESC_W-1:0] presc_o,
    output logic               pending_o
);

    logic [WIDTH-1:0]   load_q, load_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               en_q, en_d;
    logic               periodic_q, periodic_d;
    logic               ien_q, ien_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               pending_q, pending_d;
    logic               tick;
    logic               expire;
    logic               unused_wdata;

    assign unused_wdata = ^wdata_i;

    always_comb begin
        tick        = en_q && (presc_cnt_q == presc_q);
        // A COUNT write overrides the tick, so it also swallows that cycle's expiry.
        expire      = tick && (count_q == '0) && !count_we_i;
        load_d      = load_q;
        count_d     = count_q;
        en_d        = en_q;
        periodic_d  = periodic_q;
        ien_d       = ien_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        pending_d   = pending_q;

        if (en_q) presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);

        if (tick) begin
            if (count_q != '0)  count_d = count_q - WIDTH'(1);
            else if (periodic_q) count_d = load_q;
            else                 en_d    = 1'b0;
        end

        if (load_we_i) load_d = wdata_i[WIDTH-1:0];

        if (ctrl_we_i) begin
            en_d       = wdata_i[EN_BIT];
            periodic_d = wdata_i[PER_BIT];
            ien_d      = wdata_i[IEN_BIT];
            presc_d    = wdata_i[PRESC_LSB +: PRESC_W];
            if (wdata_i[EN_BIT] && !en_q) begin
                count_d     = load_q;
                presc_cnt_d = '0;
            end
        end

        if (count_we_i) count_d = wdata_i[WIDTH-1:0];

        if (clr_i)  pending_d = 1'b0;
        if (expire) pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_q      <= '0;
            count_q     <= '0;
            en_q        <= 1'b0;
            periodic_q  <= 1'b0;
            ien_q       <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            load_q      <= load_d;
            count_q     <= count_d;
            en_q        <= en_d;
            periodic_q  <= periodic_d;
            ien_q       <= ien_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            pending_q   <= pending_d;
        end
    end

    assign load_o     = load_q;
    assign count_o    = count_q;
    assign en_o       = en_q;
    assign periodic_o = periodic_q;
    assign ien_o      = ien_q;
    assign presc_o    = presc_q;
    assign pending_o  = pending_q;

endmodule

// File: rtl/timer_bank.sv
// NUM_CH timer channels behind one register window, with IRQ vector and priority-encoded ID.
module timer_bank import timer_bank_pkg::*; #(
    parameter int  NUM_CH  = 4,
    parameter int  WIDTH   = 32,
    parameter int  PRESC_W = 8,
    parameter int  ADDR_W  = 5,
    localparam int ID_W    = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    input  logic              write_enable,
    output logic [31:0]       data_out,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id
);

    localparam int                CH_W     = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(status_addr(NUM_CH));
    localparam logic [ADDR_W-1:0] INFO_A   = ADDR_W'(info_addr(NUM_CH));
    localparam logic [31:0]       INFO_VAL = {8'(WIDTH), 8'(PRESC_W), 8'd0, 8'(NUM_CH)};

    logic [CH_W-1:0]    ch_idx;
    reg_off_e           off;
    logic               addr_in_ch;
    logic [NUM_CH-1:0]  load_we, count_we, ctrl_we, clr;
    logic [NUM_CH-1:0]  pending, ch_en, ch_per, ch_ien;
    logic [WIDTH-1:0]   ch_load  [NUM_CH];
    logic [WIDTH-1:0]   ch_count [NUM_CH];
    logic [PRESC_W-1:0] ch_presc [NUM_CH];

    assign ch_idx     = addr[ADDR_W-1:2];
    assign off        = reg_off_e'(addr[1:0]);
    assign addr_in_ch = (addr < STATUS_A);

    always_comb begin
        load_we  = '0;
        count_we = '0;
        ctrl_we  = '0;
        clr      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (write_enable && addr_in_ch && (ch_idx == CH_W'(i))) begin
                load_we[i]  = (off == OFF_LOAD);
                count_we[i] = (off == OFF_COUNT);
                ctrl_we[i]  = (off == OFF_CTRL);
            end
            clr[i] = write_enable && (addr == STATUS_A) && data_in[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(
            .WIDTH   (WIDTH),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .wdata_i    (data_in),
            .load_we_i  (load_we[g]),
            .count_we_i (count_we[g]),
            .ctrl_we_i  (ctrl_we[g]),
            .clr_i      (clr[g]),
            .load_o     (ch_load[g]),
            .count_o    (ch_count[g]),
            .en_o       (ch_en[g]),
            .periodic_o (ch_per[g]),
            .ien_o      (ch_ien[g]),
            .presc_o    (ch_presc[g]),
            .pending_o  (pending[g])
        );
    end

    always_comb begin
        data_out = '0;
        if (addr_in_ch) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == CH_W'(i)) begin
                    case (off)
                        OFF_LOAD:  data_out = 32'(ch_load[i]);
                        OFF_COUNT: data_out = 32'(ch_count[i]);
                        OFF_CTRL: begin
                            data_out[EN_BIT]                = ch_en[i];
                            data_out[PER_BIT]               = ch_per[i];
                            data_out[IEN_BIT]               = ch_ien[i];
                            data_out[PRESC_LSB +: PRESC_W] = ch_presc[i];
                        end
                        default:   data_out = '0;
                    endcase
                end
            end
        end else if (addr == STATUS_A) begin
            data_out = 32'(pending);
        end else if (addr == INFO_A) begin
            data_out = INFO_VAL;
        end
    end

    assign irq_vec = pending & ch_ien;
    assign irq     = |irq_vec;

    // Scan downward so the lowest set index is the last assignment to stick.
    always_comb begin
        irq_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (irq_vec[i]) irq_id = ID_W'(i);
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank at default parameters (4 channels, 32-bit, 8-bit prescaler).
module tb_timer_bank;

    logic        clk;
    logic        rst;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic [31:0] data_out;
    logic [3:0]  irq_vec;
    logic        irq;
    logic [1:0]  irq_id;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] STATUS = 5'd16;
    localparam logic [4:0] INFO   = 5'd17;

    timer_bank dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .data_in      (data_in),
        .write_enable (write_enable),
        .data_out     (data_out),
        .irq_vec      (irq_vec),
        .irq          (irq),
        .irq_id       (irq_id)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr         = a;
        data_in      = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        chk(tag, data_out, exp);
    endtask

    initial begin
        rst          = 1'b1;
        addr         = '0;
        data_in      = '0;
        write_enable = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset state and register map
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_vec", 32'(irq_vec), 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        for (int a = 0; a < 32; a++) begin
            logic [4:0] aa;
            aa = 5'(a);
            rd(aa, (aa == INFO) ? 32'h2008_0004 : 32'd0, "rst_reg");
        end

        // Unused bits, reserved and undefined addresses
        wr(5'd14, 32'hFFFF_FFFA);
        rd(5'd14, 32'h0000_FF02, "ctrl_upper_bits");
        wr(5'd14, 32'd0);
        wr(5'd3, 32'hFFFF_FFFF);
        wr(5'd18, 32'hFFFF_FFFF);
        wr(INFO, 32'hFFFF_FFFF);
        rd(5'd3, 32'd0, "reserved_rd");
        rd(5'd18, 32'd0, "undef_rd");
        rd(INFO, 32'h2008_0004, "info_ro");
        rd(5'd0, 32'd0, "load0_untouched");

        // ch0 periodic, LOAD=3, PRESC=0: expiries 4, 8 edges after the CTRL write
        wr(5'd0, 32'd3);
        wr(5'd2, 32'h7);
        chk("p_irq_e0", 32'(irq), 32'd0);
        step(3);
        chk("p_irq_e3", 32'(irq), 32'd0);
        step(1);
        chk("p_irq_e4", 32'(irq), 32'd1);
        chk("p_vec_e4", 32'(irq_vec), 32'h1);
        rd(STATUS, 32'h1, "p_status_e4");
        wr(STATUS, 32'h1);
        chk("p_irq_clr", 32'(irq), 32'd0);
        step(2);
        chk("p_irq_e7", 32'(irq), 32'd0);
        step(1);
        chk("p_irq_e8", 32'(irq), 32'd1);
        wr(5'd2, 32'h0);
        wr(STATUS, 32'h1);
        chk("p_irq_off", 32'(irq), 32'd0);

        // ch1 one-shot, LOAD=2, PRESC=2: single expiry 9 edges after enable
        wr(5'd4, 32'd2);
        wr(5'd6, 32'h205);
        step(8);
        rd(STATUS, 32'h0, "os_status_f8");
        step(1);
        rd(STATUS, 32'h2, "os_status_f9");
        chk("os_vec", 32'(irq_vec), 32'h2);
        chk("os_id", 32'(irq_id), 32'd1);
        rd(5'd6, 32'h204, "os_ctrl_en_cleared");
        rd(5'd5, 32'd0, "os_count_zero");
        wr(STATUS, 32'h2);
        step(20);
        rd(STATUS, 32'h0, "os_no_reexpire");
        rd(5'd5, 32'd0, "os_count_still0");

        // ch2 and ch3 expire on the same edge
        wr(5'd8, 32'd2);
        wr(5'd12, 32'd1);
        wr(5'd10, 32'h5);
        wr(5'd14, 32'h5);
        step(2);
        chk("dual_vec", 32'(irq_vec), 32'hC);
        chk("dual_id", 32'(irq_id), 32'd2);
        chk("dual_irq", 32'(irq), 32'd1);
        wr(STATUS, 32'h4);
        chk("dual_id_after_clr2", 32'(irq_id), 32'd3);
        wr(STATUS, 32'h8);
        chk("dual_irq_after_clr3", 32'(irq), 32'd0);
        chk("dual_id_after_clr3", 32'(irq_id), 32'd0);

        // ch0 collisions: clear vs expiry, COUNT write vs tick
        wr(5'd2, 32'h7);
        step(3);
        wr(STATUS, 32'h1);
        rd(STATUS, 32'h1, "set_beats_clear");
        wr(5'd1, 32'd10);
        rd(5'd1, 32'd10, "count_wr_beats_tick");
        wr(STATUS, 32'h1);
        rd(5'd1, 32'd9, "count_after_wr");
        step(9);
        wr(5'd1, 32'd5);
        rd(STATUS, 32'h0, "count_wr_no_expiry");
        rd(5'd1, 32'd5, "count_wr_at_expiry");
        wr(5'd2, 32'h0);

        // ch0 with IRQ_EN=0, then enable IRQ_EN, then reset mid-count
        rd(STATUS, 32'h0, "ien_pre_status");
        wr(5'd0, 32'd1);
        wr(5'd2, 32'h3);
        step(2);
        rd(STATUS, 32'h1, "ien0_status");
        chk("ien0_irq", 32'(irq), 32'd0);
        chk("ien0_vec", 32'(irq_vec), 32'd0);
        wr(5'd2, 32'h7);
        chk("ien1_irq", 32'(irq), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_irq", 32'(irq), 32'd0);
        rd(STATUS, 32'h0, "mid_rst_status");
        rd(5'd0, 32'd0, "mid_rst_load");
        rd(5'd1, 32'd0, "mid_rst_count");
        rd(5'd2, 32'd0, "mid_rst_ctrl");
        step(3);
        rd(STATUS, 32'h0, "post_rst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
